// File: rtl/matrix_scan_rx.sv
// Row-scanned 8x8 matrix reader: drives one-hot rows, samples the column byte per row,
// and debounces each of the 64 bits across whole frames before publishing them on data.
module matrix_scan_rx #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  column_in,
  output logic [7:0]  row,
  output logic [63:0] data,
  output logic        frame_valid,
  output logic        changed
);

  localparam int             CW          = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]     DB_LIMIT    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] settle_cnt;
  logic [7:0]    sync1, sync2;
  logic [63:0]   raw;
  logic [3:0]    db_cnt     [64];
  logic [3:0]    db_cnt_nxt [64];
  logic [63:0]   data_nxt;
  logic          any_flip;

  // column_in is asynchronous; sync2 is the only consumer-visible copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= column_in;
      sync2 <= sync1;
    end
  end

  // A bit flips only after DEBOUNCE_SCANS consecutive frames disagree with data.
  always_comb begin
    data_nxt = data;
    for (int b = 0; b < 64; b++) begin
      db_cnt_nxt[b] = '0;
      if (raw[b] != data[b]) begin
        if (db_cnt[b] + 4'd1 == DB_LIMIT) begin
          data_nxt[b] = ~data[b];
        end else begin
          db_cnt_nxt[b] = db_cnt[b] + 4'd1;
        end
      end
    end
    any_flip = |(data_nxt ^ data);
  end

  // frame_valid is a one-clock pulse with no backpressure: the consumer must take
  // data on the cycle frame_valid is high; data holds until the next pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      settle_cnt  <= '0;
      row         <= '0;
      raw         <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      for (int b = 0; b < 64; b++) db_cnt[b] <= '0;
    end else begin
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      case (state)
        IDLE: begin
          row        <= '0;
          idx        <= '0;
          settle_cnt <= '0;
          if (en) begin
            state <= SCAN;
            row   <= 8'h01;
          end
        end
        SCAN: begin
          if (!en) begin
            state      <= IDLE;
            row        <= '0;
            idx        <= '0;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            raw[{idx, 3'b000} +: 8] <= sync2;
            settle_cnt              <= '0;
            if (idx == 3'd7) begin
              state <= UPDATE;
              row   <= '0;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
              row <= row << 1;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        UPDATE: begin
          data        <= data_nxt;
          frame_valid <= 1'b1;
          changed     <= any_flip;
          for (int b = 0; b < 64; b++) db_cnt[b] <= db_cnt_nxt[b];
          idx        <= '0;
          settle_cnt <= '0;
          if (en) begin
            state <= SCAN;
            row   <= 8'h01;
          end else begin
            state <= IDLE;
            row   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          row   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_rx.sv
// Bench for matrix_scan_rx: a key matrix model answers the driven rows, and a frame-level
// debounce model predicts data/changed at every frame_valid.
module tb_matrix_scan_rx;
  localparam int SC = 4;
  localparam int DB = 4;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset, en, en1;
  logic [7:0]  column_in, column_in1, row, row1;
  logic [63:0] data, data1;
  logic        frame_valid, changed, fv1, ch1;
  logic [63:0] keys;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_data;
  int          m_cnt [64];
  logic        m_changed;

  typedef struct {
    logic [63:0] keys;
    logic [63:0] exp_data;
    logic        exp_changed;
  } vec_t;
  vec_t tbl[$];

  always #5 clock = ~clock;

  // Closed keys on the driven row appear on the column lines.
  always_comb begin
    column_in = '0;
    for (int k = 0; k < 8; k++)
      if (row[k]) column_in = column_in | keys[8*k +: 8];
  end

  matrix_scan_rx #(.SETTLE_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clock(clock), .reset(reset), .en(en), .column_in(column_in),
    .row(row), .data(data), .frame_valid(frame_valid), .changed(changed));

  matrix_scan_rx #(.SETTLE_CYCLES(SC), .DEBOUNCE_SCANS(1)) dut1 (
    .clock(clock), .reset(reset), .en(en1), .column_in(column_in1),
    .row(row1), .data(data1), .frame_valid(fv1), .changed(ch1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data    = '0;
    m_changed = 1'b0;
    for (int b = 0; b < 64; b++) m_cnt[b] = 0;
  endtask

  // A bit changes once it has been seen different from data in DB frames in a row.
  task automatic model_frame(input logic [63:0] s);
    m_changed = 1'b0;
    for (int b = 0; b < 64; b++) begin
      if (s[b] == m_data[b]) m_cnt[b] = 0;
      else begin
        m_cnt[b]++;
        if (m_cnt[b] >= DB) begin
          m_data[b] = ~m_data[b];
          m_cnt[b]  = 0;
          m_changed = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_fv(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_valid && n < 60);
    if (!frame_valid) begin
      checks++;
      failures++;
      $display("FAIL fv_timeout actual=no_pulse required=pulse_within_60");
      n = -1;
    end
  endtask

  task automatic run_frame(input string name, input logic [63:0] k, input int exp_cyc);
    int n;
    keys = k;
    wait_fv(n);
    if (n < 0) return;
    chk({name, "_period"}, 64'(n), 64'(exp_cyc));
    model_frame(k);
    chk({name, "_data"}, data, m_data);
    chk({name, "_changed"}, {63'd0, changed}, {63'd0, m_changed});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] target, noise, one, k;
    reset = 1'b1; en = 1'b0; en1 = 1'b0; keys = '0; column_in1 = 8'hFF;
    model_reset();
    one = 64'd1;

    repeat (3) @(negedge clock);
    chk("rst_row", {56'd0, row}, 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_fv", {63'd0, frame_valid}, 64'd0);
    chk("rst_changed", {63'd0, changed}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_row", {56'd0, row}, 64'd0);

    // Scan order from IDLE: 8 rows x 4 clocks, one UPDATE clock, then the pulse.
    en = 1'b1;
    for (int i = 0; i < 34; i++) begin
      @(negedge clock);
      if (i <= 32) begin
        chk($sformatf("order_row_%0d", i), {56'd0, row},
            (i < 32) ? (64'd1 << (i / 4)) : 64'd0);
        chk($sformatf("order_fv_%0d", i), {63'd0, frame_valid}, 64'd0);
      end else begin
        chk("order_fv_pulse", {63'd0, frame_valid}, 64'd1);
        chk("order_row_restart", {56'd0, row}, 64'h01);
        chk("order_data", data, 64'd0);
        chk("order_changed", {63'd0, changed}, 64'd0);
        model_frame(64'd0);
      end
    end
    run_frame("empty1", 64'd0, 33);
    run_frame("empty2", 64'd0, 33);

    // Single key row3/col5 press+release, then a bouncing key at row0/col0.
    for (int i = 0; i < 4; i++)
      tbl.push_back('{64'h0000_0000_2000_0000, (i == 3) ? 64'h0000_0000_2000_0000 : 64'd0, i == 3});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{64'd0, (i == 3) ? 64'd0 : 64'h0000_0000_2000_0000, i == 3});
    for (int i = 0; i < 20; i++)
      tbl.push_back('{(i % 2 == 0) ? 64'd1 : 64'd0, 64'd0, 1'b0});
    foreach (tbl[i]) begin
      keys = tbl[i].keys;
      wait_fv(n);
      if (n < 0) break;
      model_frame(tbl[i].keys);
      chk($sformatf("tbl_period_%0d", i), 64'(n), 64'd33);
      chk($sformatf("tbl_data_%0d", i), data, tbl[i].exp_data);
      chk($sformatf("tbl_changed_%0d", i), {63'd0, changed}, {63'd0, tbl[i].exp_changed});
    end

    // Abort mid-row 5, idle 10 clocks, then restart at row 0.
    k = 64'h8001_0000_0000_0001;
    for (int i = 0; i < 4; i++) run_frame("pre_abort", k, 33);
    chk("pre_abort_value", data, k);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (row != 8'h20 && n < 40);
    chk("abort_reach_row5", {56'd0, row}, 64'h20);
    @(negedge clock);
    en = 1'b0;
    @(negedge clock);
    chk("abort_row_off", {56'd0, row}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("abort_idle_row", {56'd0, row}, 64'd0);
      chk("abort_idle_fv", {63'd0, frame_valid}, 64'd0);
    end
    chk("abort_data_kept", data, m_data);
    en = 1'b1;
    @(negedge clock);
    chk("resume_row", {56'd0, row}, 64'h01);
    run_frame("resume", k, 33);

    // Random targets with occasional single-frame bounce noise.
    target = {$urandom, $urandom};
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) target = {$urandom, $urandom};
      noise = ($urandom_range(0, 2) == 0) ? (one << $urandom_range(0, 63)) : 64'd0;
      run_frame($sformatf("rand_%0d", f), target ^ noise, 33);
    end

    // Async reset while data is all ones.
    for (int i = 0; i < 4; i++) run_frame("fill", ALL1, 33);
    chk("fill_all_ones", data, ALL1);
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_row", {56'd0, row}, 64'd0);
    chk("arst_data", data, 64'd0);
    chk("arst_fv", {63'd0, frame_valid}, 64'd0);
    chk("arst_changed", {63'd0, changed}, 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_row", {56'd0, row}, 64'h01);
    for (int i = 0; i < 4; i++) run_frame("refill", ALL1, 33);
    chk("refill_all_ones", data, ALL1);

    // DEBOUNCE_SCANS=1 instance: first frame takes all columns directly.
    @(negedge clock);
    en1 = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!fv1 && n < 60);
    chk("db1_period", 64'(n), 64'd34);
    chk("db1_data", data1, ALL1);
    chk("db1_changed", {63'd0, ch1}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
